// File: rtl/cs_window_seq.sv
// CS averaging sequencer: 9-deep sample window with running sum; one comparator scans
// the window serially for Xappr, then Y = (sum + 9*Xappr) >> 3 is strobed out.
//   state | meaning
//   IDLE  | ready for a sample; filling or holding the window
//   SCAN  | testing win[idx] for the largest entry with 9*x <= sum
//   OUT   | register Y and pulse out_valid
module cs_window_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [7:0] X,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] Y,
  output logic       out_valid
);

  localparam int WIN = 9;
  localparam int DW  = 8;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t        state;
  logic [DW-1:0] win [0:WIN-1];
  logic [3:0]    wp;
  logic [3:0]    count;
  logic [11:0]   sum;
  logic [3:0]    idx;
  logic          found;
  logic [DW-1:0] best;

  logic [11:0] sum_acc;
  logic [3:0]  count_inc;
  logic [11:0] scan_9x;
  logic [11:0] best_9x;
  logic [12:0] y_full;

  assign in_ready  = (state == IDLE);
  assign sum_acc   = sum - {4'b0000, win[wp]} + {4'b0000, X};
  assign count_inc = (count == 4'd9) ? 4'd9 : count + 4'd1;
  assign scan_9x   = ({4'b0000, win[idx]} << 3) + {4'b0000, win[idx]};
  assign best_9x   = ({4'b0000, best} << 3) + {4'b0000, best};
  // 9*255 + 2295 needs 13 bits before the shift
  assign y_full    = {1'b0, sum} + {1'b0, best_9x};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      wp        <= '0;
      count     <= '0;
      sum       <= '0;
      idx       <= '0;
      found     <= 1'b0;
      best      <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      wp        <= '0;
      count     <= '0;
      sum       <= '0;
      idx       <= '0;
      found     <= 1'b0;
      best      <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            win[wp] <= X;
            sum     <= sum_acc;
            wp      <= (wp == 4'd8) ? 4'd0 : wp + 4'd1;
            count   <= count_inc;
            if (count_inc == 4'd9) begin
              state <= SCAN;
              idx   <= '0;
              found <= 1'b0;
            end
          end
        end
        SCAN: begin
          if ((scan_9x <= sum) && (!found || (win[idx] > best))) begin
            best  <= win[idx];
            found <= 1'b1;
          end
          if (idx == 4'd8) state <= OUT;
          else             idx   <= idx + 4'd1;
        end
        OUT: begin
          Y         <= y_full[12:3];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_window_seq.sv
// Scoreboard bench for cs_window_seq: a reference model predicts each Y and its due cycle
// at accept time; a negedge monitor pops and compares whenever out_valid is seen.
module tb_cs_window_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] X = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] Y;
  logic       out_valid;

  cs_window_seq dut (
    .clk(clk), .reset(reset), .clr(clr), .X(X), .in_valid(in_valid),
    .in_ready(in_ready), .Y(Y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [9:0] y;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int mw [9];
  int mwp, mcount, msum;
  int last_acc, last_wait;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mw[i] = 0;
    mwp = 0; mcount = 0; msum = 0;
  endtask

  // Reference uses a true division for the average, not the 9*x compare.
  function automatic int model_y();
    int avg, bst;
    avg = msum / 9;
    bst = -1;
    for (int i = 0; i < 9; i++)
      if (mw[i] <= avg && mw[i] > bst) bst = mw[i];
    return (msum + 9 * bst) >> 3;
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: out_valid=1 Y=0x%03h at cycle %0d, required no strobe", Y, cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (Y !== mon_e.y) $display("FAIL strobe_value: Y=0x%03h required 0x%03h", Y, mon_e.y);
        else passes++;
        checks++;
        if (cyc != mon_e.due) $display("FAIL strobe_latency: strobe at cycle %0d required %0d", cyc, mon_e.due);
        else passes++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int x);
    int waited;
    logic [31:0] xv;
    waited = 0;
    xv = x;
    X = xv[7:0];
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    last_acc = cyc;
    last_wait = waited;
    msum = msum - mw[mwp] + x;
    mw[mwp] = x;
    mwp = (mwp + 1) % 9;
    if (mcount < 9) mcount++;
    if (mcount == 9) begin
      exp_t e;
      int yv;
      yv = model_y();
      e.y = yv[9:0];
      e.due = cyc + 10;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL missing_strobe: %0d results outstanding, required 0", sb.size());
    else passes++;
  endtask

  task automatic do_clr();
    sb.delete();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b required 1", name, in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_out_valid: got %b required 0", name, out_valid);
    else passes++;
    checks++;
    if (Y !== 10'h000) $display("FAIL %s_y: got 0x%03h required 0x000", name, Y);
    else passes++;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || Y !== 10'h000)
      $display("FAIL reset_held: out_valid=%b Y=0x%03h required 0 and 0x000", out_valid, Y);
    else passes++;
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
  endtask

  task automatic test_fill_0x10();
    do_clr();
    for (int i = 0; i < 9; i++) send(16);
    checks++;
    if (sb.size() != 1 || sb[0].y !== 10'h024)
      $display("FAIL fill_model: queued=%0d required 1 entry of 0x024", sb.size());
    else passes++;
    drain();
  endtask

  task automatic test_ramp();
    do_clr();
    for (int i = 1; i <= 9; i++) send(i);
    drain();
    checks++;
    if (Y !== 10'h00B) $display("FAIL ramp_first: Y=0x%03h required 0x00B", Y);
    else passes++;
    send(10);
    drain();
    checks++;
    if (Y !== 10'h00D) $display("FAIL ramp_slide: Y=0x%03h required 0x00D", Y);
    else passes++;
  endtask

  task automatic test_max();
    do_clr();
    for (int i = 0; i < 9; i++) send(255);
    drain();
    checks++;
    if (Y !== 10'h23D) $display("FAIL max_value: Y=0x%03h required 0x23D", Y);
    else passes++;
  endtask

  task automatic test_outlier();
    do_clr();
    for (int i = 0; i < 8; i++) send(0);
    send(100);
    drain();
    checks++;
    if (Y !== 10'h00C) $display("FAIL outlier_last: Y=0x%03h required 0x00C", Y);
    else passes++;
    do_clr();
    send(100);
    for (int i = 0; i < 8; i++) send(0);
    drain();
    checks++;
    if (Y !== 10'h00C) $display("FAIL outlier_first: Y=0x%03h required 0x00C", Y);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int e0;
    do_clr();
    for (int i = 0; i < 9; i++) begin
      send((i + 1) * 20);
      checks++;
      if (last_wait != 0) $display("FAIL fill_stall: sample %0d waited %0d cycles, required 0", i, last_wait);
      else passes++;
    end
    e0 = last_acc;
    send(5);
    checks++;
    if (last_wait != 10) $display("FAIL busy_cycles: in_ready low %0d cycles, required 10", last_wait);
    else passes++;
    checks++;
    if (last_acc != e0 + 11) $display("FAIL next_accept: accepted at cycle %0d, required %0d", last_acc, e0 + 11);
    else passes++;
    drain();
  endtask

  task automatic test_abort_reset();
    do_clr();
    for (int i = 0; i < 9; i++) send(48);
    drain();
    send(48);
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL abort_rst_scanning: in_ready=%b required 0", in_ready);
    else passes++;
    #2;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check_idle("abort_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send(5);
    repeat (12) @(negedge clk);
    send(5);
    drain();
    checks++;
    if (Y !== 10'h00B) $display("FAIL abort_rst_refill: Y=0x%03h required 0x00B", Y);
    else passes++;
  endtask

  task automatic test_abort_clr();
    send(64);
    repeat (4) @(negedge clk);
    do_clr();
    check_idle("abort_clr");
    for (int i = 0; i < 8; i++) send(9);
    repeat (12) @(negedge clk);
    send(9);
    drain();
  endtask

  task automatic test_clr_priority();
    do_clr();
    for (int i = 0; i < 8; i++) send(50);
    sb.delete();
    clr = 1'b1;
    in_valid = 1'b1;
    X = 8'd200;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 9; i++) send(7);
    drain();
    checks++;
    if (Y !== 10'h00F) $display("FAIL clr_priority: Y=0x%03h required 0x00F", Y);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_fill_0x10();
    test_ramp();
    test_max();
    test_outlier();
    test_back_to_back();
    test_abort_reset();
    test_abort_clr();
    test_clr_priority();
    repeat (15) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cs_window_seq.md
# cs_window_seq

Multi-cycle sequencer for the CS averaging function. It accepts 8-bit samples over a valid/ready handshake and keeps the 9 most recent samples in a circular window with a running sum. For each new sample after the window is full, it scans the window serially with one comparator to find Xappr, then emits the 10-bit result Y with a one-cycle strobe. It is the shared-resource, low-area front end that sits between the sample source and CS result consumers.

## Interface
- WIN, 9, window depth (fixed at 9; the arithmetic below depends on it)
- DW, 8, sample width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- clr  input  1  synchronous soft clear (same effect as reset, applied at the clock edge)
- X  input  8  sample data
- in_valid  input  1  X is valid
- in_ready  output  1  high only in state IDLE
- Y  output  10  result, registered, holds its value between strobes
- out_valid  output  1  one-cycle strobe; Y is valid while it is high

## Operation
- Storage:
  - win[0..8], 8 bits each; write pointer wp (0..8, wraps 8->0); count (0..9, saturates at 9); sum, 12 bits.
- Accept:
  - A sample is accepted on a rising edge where in_valid & in_ready.
  - On accept: sum <= sum - win[wp] + X; win[wp] <= X; wp advances; count increments.
  - Before the window is full, win entries are 0, so the subtraction is harmless.
- Definitions:
  - avg = floor(sum/9).
  - Xappr = the largest window entry x with x <= avg. It always exists because min <= avg.
  - No divider: the test is 9*x <= sum, using a 12-bit shift-add (x<<3)+x.
- Output formula: Y = (sum + 9*Xappr) >> 3, truncated. Maximum value is 573, which fits in 10 bits.
- FSM states: IDLE, SCAN, OUT.
  - IDLE: in_ready=1.
    - On accept with resulting count < 9: stay in IDLE (no output).
    - On accept with resulting count == 9: go to SCAN with idx=0, found=0.
  - SCAN: in_ready=0. Examine win[idx] each cycle, idx 0..8.
    - If 9*win[idx] <= sum and (!found or win[idx] > best): best <= win[idx], found <= 1.
    - After idx==8, go to OUT.
  - OUT: register Y from sum and best, assert out_valid, return to IDLE.
- Scan order is irrelevant to the result; ties on equal values give the same best.
- clr, or reset at any time: state=IDLE, count=0, wp=0, sum=0, win all 0, best=0, Y=0, out_valid=0.
  - An in-progress scan is aborted and produces no strobe.
  - clr has priority over a coincident accept; that sample is dropped.

## Timing
- Reset values: in_ready=1 after reset deasserts, out_valid=0, Y=0x000.
- Let E0 be the accept edge that makes count 9:
  - SCAN runs on edges E1..E9 (idx 0..8).
  - OUT state occupies the cycle after E9.
  - Y and out_valid are registered at E10. out_valid is high from E10 to E11.
  - Latency from the accept edge to the strobe: 10 cycles.
- in_ready rises after E10, so the next accept can occur at E11 at the earliest. Full-window throughput is 1 sample per 11 cycles.
- While count < 9, back-to-back accepts are allowed, one per cycle.
- in_valid held high while in_ready=0 is not an accept. X must be held by the source until it is accepted.
- Y changes only at out_valid edges, at reset, or at clr.

## Test plan
- Nine samples 0x10 back-to-back -> no strobe for samples 1-8; out_valid exactly 10 cycles after the 9th accept; Y=0x024.
- Samples 1,2,...,9 -> Y=0x00B. Then push 10 (window 2..10, sum 54) -> Y=0x00D.
- Nine samples 0xFF -> Y=0x23D. Confirms no 12-bit sum overflow and the 10-bit width.
- Window {0,0,0,0,0,0,0,0,100} (avg 11) -> Xappr=0, Y=0x00C. Window {100,0,...,0} in reverse order -> same Y.
- Backpressure case:
  - Stimulus: hold in_valid=1 with a new X during SCAN and OUT.
  - Response: in_ready=0 for exactly 10 cycles, no extra accept, and the sample is taken at E11.
- Abort case:
  - Stimulus: assert reset asynchronously (and separately clr) at SCAN idx=4.
  - Response: out_valid never pulses, Y=0x000, in_ready=1. The next 8 samples produce no strobe; the 9th does.
